// File: rtl/pp_accum_pkg.sv
// Shared types and default sizing for the partial-product accumulator.
package pp_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int PP_DATA_W_DEF    = 21;
    localparam int PP_ACC_W_DEF     = 28;
    localparam int PP_MAX_TERMS_DEF = 64;

endpackage

// File: rtl/pp_add_sat.sv
// ACC_W+1 adder with carry-out; saturating when PP_ACCUM_SAT_EN is defined,
// wrapping modulo 2^ACC_W otherwise.
module pp_add_sat
    import pp_accum_pkg::*;
#(
    parameter int DATA_W = PP_DATA_W_DEF,
    parameter int ACC_W  = PP_ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

`ifdef PP_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [ACC_W:0] wide;

    // Once saturated, acc stays all-ones: any non-zero addend carries out again.
    function automatic logic [ACC_W-1:0] sat_or_wrap(input logic [ACC_W-1:0] lo,
                                                     input logic            c);
        return (c && SAT) ? {ACC_W{1'b1}} : lo;
    endfunction

    always_comb begin
        wide  = {1'b0, acc} + (ACC_W+1)'(addend);
        carry = wide[ACC_W];
        sum   = sat_or_wrap(wide[ACC_W-1:0], wide[ACC_W]);
    end

endmodule

// File: rtl/pp_accum.sv
// Group accumulator for shifted partial products with a held, handshaked result.
// Overflow handling is selected by PP_ACCUM_SAT_EN (saturate) or its absence (wrap).
module pp_accum
    import pp_accum_pkg::*;
#(
    parameter int DATA_W    = PP_DATA_W_DEF,
    parameter int ACC_W     = PP_ACC_W_DEF,
    parameter int MAX_TERMS = PP_MAX_TERMS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              out_len_err
);

    localparam int               CNT_W   = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    state_t           state_p1, nxt_state;
    logic [ACC_W-1:0] acc_p1, add_base, add_sum;
    logic [CNT_W-1:0] cnt_p1, cnt_inc;
    logic             ovf_p1, len_err_p1, add_carry;
    logic             accept, at_max, close_grp;

    // Stage p0: term qualification and add
    always_comb begin
        add_base  = (state_p1 == IDLE) ? '0 : acc_p1;
        cnt_inc   = (state_p1 == IDLE) ? CNT_W'(1) : cnt_p1 + CNT_W'(1);
        accept    = in_valid && in_ready;
        at_max    = (cnt_inc == MAX_CNT);
        close_grp = accept && (in_last || at_max);
    end

    pp_add_sat #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc    (add_base),
        .addend (in_data),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1 <= IDLE;
        end else begin
            state_p1 <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state_p1;
        case (state_p1)
            IDLE, ACCUM: begin
                if (close_grp) begin
                    nxt_state = HOLD;
                end else if (accept) begin
                    nxt_state = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_p1 != HOLD) && !rst;
        out_valid = (state_p1 == HOLD);
    end

    // Stage p1: accumulator, term count and sticky group flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p1     <= '0;
            cnt_p1     <= '0;
            ovf_p1     <= 1'b0;
            len_err_p1 <= 1'b0;
        end else if (state_p1 == HOLD) begin
            if (out_ready) begin
                acc_p1     <= '0;
                cnt_p1     <= '0;
                ovf_p1     <= 1'b0;
                len_err_p1 <= 1'b0;
            end
        end else if (accept) begin
            acc_p1     <= add_sum;
            cnt_p1     <= cnt_inc;
            ovf_p1     <= ovf_p1 | add_carry;
            len_err_p1 <= at_max && !in_last;
        end
    end

    assign out_sum     = acc_p1;
    assign out_ovf     = ovf_p1;
    assign out_len_err = len_err_p1;

endmodule

// File: tb/tb_pp_accum.sv
// Directed bench for pp_accum: a default-width and a 21-bit-accumulator instance
// share stimulus and are checked every cycle against a group-sum model.
module tb_pp_accum;

    localparam int  DW        = 21;
    localparam int  AW_A      = 28;
    localparam int  AW_B      = 21;
    localparam int  MAX_TERMS = 64;
`ifdef PP_ACCUM_SAT_EN
    localparam longint OVF_SUM_B = 64'h1FFFFF;
`else
    localparam longint OVF_SUM_B = 64'd1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid, in_last, out_ready;
    logic [DW-1:0] in_data;

    logic in_ready_a, out_valid_a, out_ovf_a, out_len_err_a;
    logic in_ready_b, out_valid_b, out_ovf_b, out_len_err_b;
    logic [AW_A-1:0] out_sum_a;
    logic [AW_B-1:0] out_sum_b;

    int checks = 0;
    int passes = 0;

    pp_accum u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_ovf(out_ovf_a), .out_len_err(out_len_err_a)
    );

    pp_accum #(.DATA_W(DW), .ACC_W(AW_B), .MAX_TERMS(MAX_TERMS)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_ovf(out_ovf_b), .out_len_err(out_len_err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, want, $time);
        end else begin
            passes++;
        end
    endtask

    // Model: the exact (unbounded) group total, then reduced to the result width.
    bit     m_hold = 1'b0;
    bit     m_len  = 1'b0;
    longint m_raw  = 0;
    int     m_cnt  = 0;

    function automatic longint exp_sum(input longint raw, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef PP_ACCUM_SAT_EN
        return (raw > mx) ? mx : raw;
`else
        return raw & mx;
`endif
    endfunction

    function automatic bit exp_ovf(input longint raw, input int w);
        return raw > ((longint'(1) << w) - 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hold <= 1'b0; m_raw <= 0; m_cnt <= 0; m_len <= 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold <= 1'b0; m_raw <= 0; m_cnt <= 0; m_len <= 1'b0;
            end
        end else if (in_valid) begin
            m_raw <= m_raw + longint'(in_data);
            m_cnt <= m_cnt + 1;
            if (in_last || (m_cnt + 1 == MAX_TERMS)) begin
                m_hold <= 1'b1;
                m_len  <= !in_last;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid_a", 64'(out_valid_a), 0);
            chk("rst_ready_a", 64'(in_ready_a), 0);
            chk("rst_sum_a", 64'(out_sum_a), 0);
            chk("rst_flags_a", 64'({out_ovf_a, out_len_err_a}), 0);
            chk("rst_ready_b", 64'(in_ready_b), 0);
        end else begin
            chk("valid_a", 64'(out_valid_a), 64'(m_hold));
            chk("ready_a", 64'(in_ready_a), 64'(!m_hold));
            chk("valid_b", 64'(out_valid_b), 64'(m_hold));
            chk("ready_b", 64'(in_ready_b), 64'(!m_hold));
            if (m_hold) begin
                chk("sum_a", 64'(out_sum_a), exp_sum(m_raw, AW_A));
                chk("ovf_a", 64'(out_ovf_a), 64'(exp_ovf(m_raw, AW_A)));
                chk("len_a", 64'(out_len_err_a), 64'(m_len));
                chk("sum_b", 64'(out_sum_b), exp_sum(m_raw, AW_B));
                chk("ovf_b", 64'(out_ovf_b), 64'(exp_ovf(m_raw, AW_B)));
                chk("len_b", 64'(out_len_err_b), 64'(m_len));
            end
        end
    end

    task automatic beat(input logic [DW-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Returns at the negedge where out_valid is first seen; lat counts negedges waited.
    task automatic collect(input string name);
        int lat;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid_a === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk(name, 64'(lat), 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Basic three-term group
        beat(5, 0); beat(10, 0); beat(20, 1); idle();
        collect("lat_35");
        chk("lit_sum_35", 64'(out_sum_a), 35);
        chk("lit_ovf_35", 64'(out_ovf_a), 0);
        chk("lit_len_35", 64'(out_len_err_a), 0);
        step();

        // Forced close at MAX_TERMS
        for (int i = 0; i < MAX_TERMS; i++) beat(21'h1FFFFF, 0);
        idle();
        collect("lat_force");
        chk("lit_sum_force", 64'(out_sum_a), 134217664);
        chk("lit_len_force", 64'(out_len_err_a), 1);
        chk("lit_ovf_force", 64'(out_ovf_a), 0);
        step();

        // Overflow on the narrow accumulator
        beat(21'h1FFFFF, 0); beat(2, 1); idle();
        collect("lat_ovf");
        chk("lit_ovf_b", 64'(out_ovf_b), 1);
        chk("lit_sum_b", 64'(out_sum_b), OVF_SUM_B);
        chk("lit_sum_a_wide", 64'(out_sum_a), 2097153);
        step();

        // Backpressure with input pending, then clean restart
        out_ready = 1'b0;
        beat(3, 0); beat(4, 1);
        in_valid = 1'b1; in_data = 123; in_last = 1'b0;
        collect("lat_hold");
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("lit_hold_ready", 64'(in_ready_a), 0);
            chk("lit_hold_sum", 64'(out_sum_a), 7);
        end
        out_ready = 1'b1;
        step();
        chk("lit_release_valid", 64'(out_valid_a), 0);
        beat(123, 0); beat(5, 1); idle();
        collect("lat_restart");
        chk("lit_restart_sum", 64'(out_sum_a), 128);
        step();

        // Reset mid-group discards the partial sum
        beat(1, 0); beat(2, 0); beat(3, 0); idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_no_out_after_rst", 64'(out_valid_a), 0);
        end
        step();
        beat(7, 1); idle();
        collect("lat_7");
        chk("lit_sum_7", 64'(out_sum_a), 7);
        step();

        // Single-beat group, then a group with bubbles
        beat(9, 1); idle();
        collect("lat_9");
        chk("lit_sum_9", 64'(out_sum_a), 9);
        step();
        beat(4, 0); idle();
        repeat (3) step();
        beat(6, 0); idle();
        repeat (2) step();
        beat(1, 1); idle();
        collect("lat_11");
        chk("lit_sum_11", 64'(out_sum_a), 11);
        step();

        repeat (2) step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pp_accum.md
PP_ACCUM -- requirements
Module: pp_accum

Interface
REQ-001 The block SHALL have parameter DATA_W, default 21, meaning the width of the incoming shifted partial product.
REQ-002 The block SHALL have parameter ACC_W, default 28, meaning the accumulator and result width (ACC_W >= DATA_W).
REQ-003 The block SHALL have parameter MAX_TERMS, default 64, meaning the maximum number of terms per group (8 i values x 8 j values).
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have the port in_valid, input, 1 bit: the upstream partial product is valid.
REQ-007 The block SHALL have the port in_data, input, DATA_W bits: the unsigned shifted partial product from the lookup stage.
REQ-008 The block SHALL have the port in_last, input, 1 bit: this beat is the final term of the group.
REQ-009 The block SHALL have the port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 The block SHALL have the port out_valid, output, 1 bit: the result is held and valid.
REQ-011 The block SHALL have the port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have the port out_sum, output, ACC_W bits: the accumulated group sum.
REQ-013 The block SHALL have the port out_ovf, output, 1 bit: the group sum exceeded 2^ACC_W-1.
REQ-014 The block SHALL have the port out_len_err, output, 1 bit: the group was force-closed at MAX_TERMS without in_last.

Function
REQ-015 The block SHALL implement the states IDLE (acc=0, count=0), ACCUM and HOLD.
REQ-016 A beat SHALL be accepted only when in_valid && in_ready; in_ready SHALL be 1 in IDLE/ACCUM and 0 in HOLD.
REQ-017 An accepted beat in IDLE SHALL load acc=in_data zero-extended and count=1; in ACCUM it SHALL set acc=acc+in_data and count=count+1.
REQ-018 An accepted beat with in_last=1 SHALL move the block to HOLD; out_valid SHALL rise the cycle after that beat (latency 1), with out_sum including the last term.
REQ-019 An accepted beat that brings count to MAX_TERMS with in_last=0 SHALL be treated as the last beat and SHALL set out_len_err=1 for that result.
REQ-020 The addition SHALL use ACC_W+1 bits; a carry-out on any term SHALL set the sticky group flag out_ovf, and the stored value SHALL follow REQ-027.
REQ-021 In HOLD, out_sum, out_ovf and out_len_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 HOLD with out_ready=1 SHALL go to IDLE next cycle, clearing acc, count and flags; no input beat SHALL be accepted in that same cycle (no bypass).
REQ-023 in_valid=0 in ACCUM SHALL hold all state (bubbles allowed between terms).
REQ-024 in_data SHALL be ignored whenever in_valid=0 or in_ready=0.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, acc=0, count=0, out_valid=0, out_sum=0, out_ovf=0, out_len_err=0, in_ready=0 while rst is asserted, and in_ready=1 from the first clock edge after release.
REQ-026 Reset mid-group or in HOLD SHALL discard the partial group with no output produced.

Configuration
REQ-027 With PP_ACCUM_SAT_EN defined, an overflowing add SHALL saturate acc to 2^ACC_W-1 and hold it there for the rest of the group; without it, acc SHALL wrap modulo 2^ACC_W; out_ovf SHALL behave identically in both builds.

Structure
REQ-028 The package pp_accum_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD) and the default constants DATA_W=21, ACC_W=28, MAX_TERMS=64.
REQ-029 The sub-module pp_add_sat (ACC_W+1 adder, carry-out, saturate/wrap select controlled by PP_ACCUM_SAT_EN) SHALL be the only child.

Verification
REQ-030 Beats 5, 10, 20 (last on 20), out_ready=1 -> out_sum=35, ovf=0, len_err=0, out_valid exactly 1 cycle after the last beat.
REQ-031 64 beats of 21'h1FFFFF without last -> forced close on beat 64, out_sum=64*2097151=134217664, len_err=1, ovf=0.
REQ-032 ACC_W=21, beats 21'h1FFFFF, 2 (last) -> ovf=1; out_sum=21'h1FFFFF with PP_ACCUM_SAT_EN, 1 without.
REQ-033 Result held with out_ready=0 for 10 cycles while in_valid=1 -> in_ready=0, out_sum stable, no beat consumed; out_ready=1 -> IDLE next cycle, the next group starts clean.
REQ-034 rst pulsed after 3 of 5 beats -> out_valid never rises; a new group 7 (last) -> out_sum=7.
REQ-035 Single beat 9 with in_last=1 from IDLE -> out_sum=9 after 1 cycle; in_valid bubbles inside a group do not change the sum.
